// File: rtl/cfg_frame_loader.sv
// Byte-stream configuration loader: SYNC/ADDR/D0/D1/D2 frames become one-hot block writes.
// Optional CFG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte per frame.
module cfg_frame_loader #(
  parameter int NUM_BLOCKS = 16,
  parameter int FRAME_W    = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FRAME_W-1:0]    bits,
  output logic [NUM_BLOCKS-1:0] wr_en,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [7:0]            frame_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_D0    = 3'd2;
  localparam logic [2:0] S_D1    = 3'd3;
  localparam logic [2:0] S_D2    = 3'd4;
`ifdef CFG_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd5;
`endif
  localparam logic [2:0] S_WRITE = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] END_ADDR  = 8'hFF;
  localparam logic [8:0] NB        = 9'(NUM_BLOCKS);

  logic [2:0]            state;
  logic [7:0]            addr_q, d0_q, d1_q;
  logic                  xfer, load;
  logic [FRAME_W-1:0]    payload;
  logic [NUM_BLOCKS-1:0] sel;

  assign in_ready = (state != S_WRITE) && (state != S_DONE);
  assign xfer     = in_valid && in_ready;

  for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_sel
    assign sel[g] = (addr_q == 8'(g));
  end

`ifdef CFG_LOADER_CHECKSUM_EN
  logic [7:0] d2_q;
  logic       chk_ok;
  assign chk_ok  = (in_data == (addr_q ^ d0_q ^ d1_q ^ d2_q));
  assign payload = {d0_q[1:0], d1_q, d2_q};
  assign load    = xfer && (state == S_CHK) && chk_ok;
`else
  // D2 goes straight onto the bus so WRITE is the cycle right after it
  assign payload = {d0_q[1:0], d1_q, in_data};
  assign load    = xfer && (state == S_D2);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
`ifdef CFG_LOADER_CHECKSUM_EN
      d2_q      <= '0;
`endif
      bits      <= '0;
      wr_en     <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      wr_en <= '0;
      if (load) begin
        bits  <= payload;
        wr_en <= sel;
        if (frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
      end
      case (state)
        S_IDLE: if (xfer && in_data == SYNC_BYTE) state <= S_ADDR;
        S_ADDR: if (xfer) begin
          if (in_data == END_ADDR) begin
            state    <= S_DONE;
            cfg_done <= 1'b1;
          end else if ({1'b0, in_data} >= NB) begin
            cfg_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            addr_q <= in_data;
            state  <= S_D0;
          end
        end
        S_D0: if (xfer) begin
          if (|in_data[7:2]) begin
            cfg_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            d0_q  <= in_data;
            state <= S_D1;
          end
        end
        S_D1: if (xfer) begin
          d1_q  <= in_data;
          state <= S_D2;
        end
`ifdef CFG_LOADER_CHECKSUM_EN
        S_D2: if (xfer) begin
          d2_q  <= in_data;
          state <= S_CHK;
        end
        S_CHK: if (xfer) begin
          if (chk_ok) state <= S_WRITE;
          else begin
            cfg_err <= 1'b1;
            state   <= S_IDLE;
          end
        end
`else
        S_D2: if (xfer) state <= S_WRITE;
`endif
        S_WRITE: state <= S_IDLE;
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
